// File: rtl/flow_reshaper_tiled.sv
// flow_reshaper_tiled: reads one IMG_W x IMG_H frame from a fixed-latency
// source RAM in raster, tile-major or transpose order and writes it out to a
// sequential destination, one pixel per cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for ena; latches mode and clears counters on start
// S_RUN   | one read per cycle, N reads back to back
// S_DRAIN | no new reads; in-flight reads land as writes (RD_LAT+1 cycles)
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module flow_reshaper_tiled #(
  parameter int DW      = 8,
  parameter int AW      = 20,
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int TILE_W  = 8,
  parameter int TILE_H  = 8,
  parameter int RD_LAT  = 1,
  parameter int RD_BASE = 0,
  parameter int WR_BASE = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ena,
  input  logic [1:0]    mode,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  localparam int N = IMG_W * IMG_H;

  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW-1:0] N_M1    = AW'(N - 1);
  localparam logic [AW-1:0] W_A     = AW'(IMG_W);
  localparam logic [AW-1:0] H_M1    = AW'(IMG_H - 1);
  localparam logic [AW-1:0] TW_A    = AW'(TILE_W);
  localparam logic [AW-1:0] TW_M1   = AW'(TILE_W - 1);
  localparam logic [AW-1:0] TH_M1   = AW'(TILE_H - 1);
  localparam logic [AW-1:0] TX_M1   = AW'(IMG_W / TILE_W - 1);
  localparam logic [AW-1:0] BAND_A  = AW'(TILE_H * IMG_W);
  localparam logic [AW-1:0] RD_B    = AW'(RD_BASE);
  localparam logic [AW-1:0] WR_B    = AW'(WR_BASE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [AW-1:0]   rd_left;
  logic [2:0]      drain_left;
  // c_cnt: pixel within tile row (tile) or y within column (transpose)
  logic [AW-1:0]   c_cnt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   tx_cnt;
  // row_base: start of current tile row (tile) or column base (transpose)
  logic [AW-1:0]   row_base;
  logic [AW-1:0]   tile_base;
  logic [AW-1:0]   band_base;
  logic [RD_LAT-1:0] rd_pipe;
  logic [AW-1:0]   wr_idx;

  // Control FSM and read-address generator (incremental, no multipliers).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      mode_q     <= 2'd0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_left    <= '0;
      drain_left <= 3'd0;
      c_cnt      <= '0;
      r_cnt      <= '0;
      tx_cnt     <= '0;
      row_base   <= '0;
      tile_base  <= '0;
      band_base  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ena) begin
            state     <= S_RUN;
            mode_q    <= mode;
            rd_en     <= 1'b1;
            rd_addr   <= RD_B;
            busy      <= 1'b1;
            rd_left   <= N_M1;
            c_cnt     <= '0;
            r_cnt     <= '0;
            tx_cnt    <= '0;
            row_base  <= RD_B;
            tile_base <= RD_B;
            band_base <= RD_B;
          end
        end
        S_RUN: begin
          if (rd_left == '0) begin
            state      <= S_DRAIN;
            rd_en      <= 1'b0;
            drain_left <= 3'(RD_LAT);
          end else begin
            rd_left <= rd_left - ONE_A;
            if (mode_q == 2'd1) begin
              if (c_cnt != TW_M1) begin
                c_cnt   <= c_cnt + ONE_A;
                rd_addr <= rd_addr + ONE_A;
              end else begin
                c_cnt <= '0;
                if (r_cnt != TH_M1) begin
                  r_cnt    <= r_cnt + ONE_A;
                  row_base <= row_base + W_A;
                  rd_addr  <= row_base + W_A;
                end else begin
                  r_cnt <= '0;
                  if (tx_cnt != TX_M1) begin
                    tx_cnt    <= tx_cnt + ONE_A;
                    tile_base <= tile_base + TW_A;
                    row_base  <= tile_base + TW_A;
                    rd_addr   <= tile_base + TW_A;
                  end else begin
                    tx_cnt    <= '0;
                    band_base <= band_base + BAND_A;
                    tile_base <= band_base + BAND_A;
                    row_base  <= band_base + BAND_A;
                    rd_addr   <= band_base + BAND_A;
                  end
                end
              end
            end else if (mode_q == 2'd2) begin
              if (c_cnt != H_M1) begin
                c_cnt   <= c_cnt + ONE_A;
                rd_addr <= rd_addr + W_A;
              end else begin
                c_cnt    <= '0;
                row_base <= row_base + ONE_A;
                rd_addr  <= row_base + ONE_A;
              end
            end else begin
              rd_addr <= rd_addr + ONE_A;
            end
          end
        end
        S_DRAIN: begin
          if (drain_left == 3'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_left <= drain_left - 3'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid pipeline for in-flight reads; registers the write when data lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pipe <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_idx  <= '0;
    end else begin
      rd_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      wr_en <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) begin
        wr_data <= rd_data;
        wr_addr <= WR_B + wr_idx;
        wr_idx  <= wr_idx + ONE_A;
      end else if (state == S_IDLE && ena) begin
        wr_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flow_reshaper_tiled.sv
// Bench for flow_reshaper_tiled: a latency-accurate RAM model feeds the DUT,
// a reference model fills expectation queues per frame and a negedge
// monitor checks strobes, addresses and data against them.
module tb_flow_reshaper_tiled;

  localparam int DW      = 8;
  localparam int AW      = 10;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 4;
  localparam int TILE_W  = 4;
  localparam int TILE_H  = 2;
  localparam int RD_LAT  = 3;
  localparam int RD_BASE = 100;
  localparam int WR_BASE = 16;
  localparam int N        = IMG_W * IMG_H;
  localparam int DONE_REL = N + RD_LAT + 2;

  logic          clk;
  logic          rstn;
  logic          ena;
  logic [1:0]    mode;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  int   cyc = 0;
  int   t0 = 0;
  bit   active = 0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] seed;
  int   exp_rd[$];
  int   exp_wa[$];
  int   exp_wd[$];
  logic [AW-1:0] da [1:RD_LAT];
  int   mrel;

  flow_reshaper_tiled #(
    .DW(DW), .AW(AW), .IMG_W(IMG_W), .IMG_H(IMG_H), .TILE_W(TILE_W),
    .TILE_H(TILE_H), .RD_LAT(RD_LAT), .RD_BASE(RD_BASE), .WR_BASE(WR_BASE)
  ) dut (
    .clk(clk), .rstn(rstn), .ena(ena), .mode(mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a, input logic [7:0] s);
    logic [15:0] t;
    t = 16'(a) * 16'd29 + 16'(s);
    t = t ^ (t >> 5);
    return t[DW-1:0];
  endfunction

  // Source RAM: data for the address read in cycle t is presented in t+RD_LAT.
  always @(posedge clk) begin
    da[1] <= rd_addr;
    for (int i = 2; i <= RD_LAT; i++) da[i] <= da[i-1];
  end
  assign rd_data = mem_f(da[RD_LAT], seed);

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Reference model: traversal order straight from the address formulas.
  task automatic build(input logic [1:0] m);
    int addrs[$];
    addrs = {};
    if (m == 2'd1) begin
      for (int ty = 0; ty < IMG_H / TILE_H; ty++)
        for (int tx = 0; tx < IMG_W / TILE_W; tx++)
          for (int r = 0; r < TILE_H; r++)
            for (int c = 0; c < TILE_W; c++)
              addrs.push_back(RD_BASE + (ty * TILE_H + r) * IMG_W + tx * TILE_W + c);
    end else if (m == 2'd2) begin
      for (int x = 0; x < IMG_W; x++)
        for (int y = 0; y < IMG_H; y++)
          addrs.push_back(RD_BASE + y * IMG_W + x);
    end else begin
      for (int y = 0; y < IMG_H; y++)
        for (int x = 0; x < IMG_W; x++)
          addrs.push_back(RD_BASE + y * IMG_W + x);
    end
    for (int k = 0; k < N; k++) begin
      exp_rd.push_back(addrs[k]);
      exp_wa.push_back(WR_BASE + k);
      exp_wd.push_back(int'(mem_f(AW'(addrs[k]), seed)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m);
    ena    = 1'b1;
    mode   = m;
    t0     = cyc;
    active = 1'b1;
    build(m);
    step();
    ena  = 1'b0;
    mode = 2'($urandom_range(0, 3));
  endtask

  // Runs to the done cycle; noise pulses ena and changes mode mid-frame.
  task automatic wait_done(input bit noise);
    while (cyc < t0 + DONE_REL) begin
      ena  = noise && ($urandom_range(0, 3) == 0);
      mode = 2'($urandom_range(0, 3));
      step();
    end
    ena = 1'b0;
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("wr_queue_drained", exp_wa.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Monitor: strobe timing from the frame window, payloads from the queues.
  always @(negedge clk) begin
    if (rstn) begin
      mrel = active ? (cyc - t0) : -1;
      chk("rd_en", rd_en, (mrel >= 1 && mrel <= N));
      chk("wr_en", wr_en, (mrel >= RD_LAT + 2 && mrel <= N + RD_LAT + 1));
      chk("busy", busy, (mrel >= 1 && mrel <= N + RD_LAT + 1));
      chk("done", done, (mrel == DONE_REL));
      if (rd_en) begin
        if (exp_rd.size() == 0) fail_now("rd_extra");
        else chk("rd_addr", rd_addr, exp_rd.pop_front());
      end
      if (wr_en) begin
        if (exp_wa.size() == 0) fail_now("wr_extra");
        else begin
          chk("wr_addr", wr_addr, exp_wa.pop_front());
          chk("wr_data", wr_data, exp_wd.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = 8'($urandom);
    rstn = 1'b0;
    ena  = 1'b0;
    mode = 2'd0;
    step();
    step();
    check_zero("reset");
    rstn = 1'b1;
    repeat (3) step();

    // each traversal mode once, including mode 3 as raster
    for (int m = 0; m < 4; m++) begin
      start(2'(m));
      wait_done(0);
      step();
      step();
    end

    // ena at rel 10 and in the done cycle ignored; next cycle starts a frame
    start(2'd1);
    while (cyc < t0 + 10) step();
    ena = 1'b1;
    step();
    ena = 1'b0;
    wait_done(0);
    ena = 1'b1;
    step();
    start(2'd2);
    wait_done(1);
    step();

    // reset mid-frame discards in-flight work
    start(2'd0);
    while (cyc < t0 + 20) step();
    rstn = 1'b0;
    active = 1'b0;
    exp_rd = {};
    exp_wa = {};
    exp_wd = {};
    #1;
    check_zero("midreset");
    step();
    step();
    rstn = 1'b1;
    repeat (12) step();
    start(2'($urandom_range(0, 3)));
    wait_done(1);
    step();

    // randomized frames with random gaps, mode noise and ignored ena pulses
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) step();
      start(2'($urandom_range(0, 3)));
      wait_done(1);
      step();
    end
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flow_reshaper_tiled.md
Name: flow_reshaper_tiled

Overview:
- Parametrised successor of the single-mode flow reshaper.
- Streams one IMG_W x IMG_H frame out of a source RAM that has a fixed read latency. Writes the frame sequentially to a destination port in one of three traversal orders: raster copy, tile-major, or transpose.
- Sits between a frame buffer and downstream tile/column consumers.
- Started by a one-cycle ena pulse. Reports busy and a done pulse.

Parameters:
- DW, 8, pixel data width.
- AW, 20, read/write address width. Requires IMG_W*IMG_H + max(RD_BASE, WR_BASE) <= 2^AW.
- IMG_W, 320, frame width in pixels.
- IMG_H, 240, frame height in pixels.
- TILE_W, 8, tile width. IMG_W must be a multiple of TILE_W.
- TILE_H, 8, tile height. IMG_H must be a multiple of TILE_H.
- RD_LAT, 1, source RAM read latency in cycles (1..4).
- RD_BASE, 0, offset added to every rd_addr.
- WR_BASE, 0, offset added to every wr_addr.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- ena  in  1  start pulse, sampled only in IDLE.
- mode  in  2  traversal order, latched on an accepted ena: 0 raster, 1 tile-major, 2 transpose, 3 treated as raster.
- rd_en  out  1  source read strobe.
- rd_addr  out  AW  source read address.
- rd_data  in  DW  source data, valid RD_LAT cycles after its rd_en cycle.
- wr_en  out  1  destination write strobe.
- wr_addr  out  AW  destination address.
- wr_data  out  DW  destination data.
- busy  out  1  frame in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, latched mode is 0. Reset mid-frame discards all in-flight reads; no wr_en follows deassertion.
- FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: ena=1 latches mode, clears counters and moves to RUN. ena=0 stays in IDLE.
- RUN: rd_en=1 every cycle, one address per cycle, N=IMG_W*IMG_H cycles with no gaps. After the N-th read, move to DRAIN.
- DRAIN: lasts RD_LAT+1 cycles, until the last write has issued.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- busy is 1 from the first RUN cycle through the cycle of the last wr_en.
- ena outside IDLE is ignored. ena coincident with the done cycle is ignored (FSM is in DONE, not IDLE). mode changes after acceptance have no effect.
- Read address, k-th read, all terms zero-based:
  - Raster (modes 0 and 3): x inner, y outer. rd_addr = RD_BASE + y*IMG_W + x.
  - Tile-major (mode 1): c inner, then r, then tx, then ty outermost. rd_addr = RD_BASE + (ty*TILE_H + r)*IMG_W + tx*TILE_W + c.
  - Transpose (mode 2): y inner, x outer. rd_addr = RD_BASE + y*IMG_W + x.
- Address generation: row-base accumulators with incremental adds, no runtime multipliers. Counter wrap must be exact at every tile and frame edge.
- Write timing: the read issued in cycle t produces a registered write in cycle t+RD_LAT+1.
  - wr_data is rd_data captured at the end of cycle t+RD_LAT.
  - wr_addr = WR_BASE + k, strictly sequential 0..N-1 plus offset.
- Throughput: one pixel per cycle.
- Total cycles from the accepted ena edge to the done pulse: N+RD_LAT+2.
- A pipeline of RD_LAT+1 valid bits tracks in-flight reads. Write-side order equals read-side order.

Test Plan:
- Raster, default params, RAM holding addr[7:0]: ena at edge 0 -> rd_en cycles 1..76800; wr_en cycles 3..76802 with wr_addr 0..76799; wr_data = wr_addr[7:0]; done=1 only in cycle 76803.
- IMG 4x4, TILE 2x2, mode 1 -> rd_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; wr_addr 0..15.
- IMG 4x4, mode 2 -> rd_addr sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. mode=3 gives the same sequence as mode 0.
- RD_LAT=3, RD_BASE=100, WR_BASE=16 -> first rd_addr 100 in cycle 1; first wr_en in cycle 5 with wr_addr 16 and wr_data = RAM[100].
- ena pulsed again in cycle 10, and again in the done cycle -> both ignored, exactly N writes. ena in the cycle after done starts a new frame.
- rstn low in cycle 20 of a 4x4 frame -> all outputs 0 immediately; no wr_en after release. A fresh ena then completes a full 16-write frame.
